// File: rtl/beh_cond_pkg.sv
// Shared constants and types for the beh_cond programmable 4-input logic cell.
package beh_cond_pkg;
    localparam int BEH_COND_IDX_W   = 4;
    localparam int BEH_COND_TABLE_W = 16;

    typedef logic [BEH_COND_TABLE_W-1:0] beh_cond_table_t;

    // Reset table: a ? b : (c ^ d)
    localparam beh_cond_table_t BEH_COND_DEFAULT_TABLE = 16'hF066;
endpackage

// File: rtl/beh_cond_lut.sv
// Combinational 16-entry truth-table lookup: f = table[idx].
module beh_cond_lut
    import beh_cond_pkg::*;
(
    input  beh_cond_table_t             table_i,
    input  logic [BEH_COND_IDX_W-1:0]   idx_i,
    output logic                        f_o
);

    assign f_o = table_i[idx_i];

endmodule

// File: rtl/beh_cond.sv
// Programmable 4-input conditional logic cell with saturating output-change counter.
// Define BEH_COND_REG_OUT_EN to register y (one cycle latency, reset value 0).
module beh_cond
    import beh_cond_pkg::*;
#(
    parameter int              CNT_W         = 8,
    parameter beh_cond_table_t DEFAULT_TABLE = BEH_COND_DEFAULT_TABLE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a,
    input  logic                        b,
    input  logic                        c,
    input  logic                        d,
    input  logic                        cfg_we,
    input  logic [BEH_COND_TABLE_W-1:0] cfg_data,
    input  logic                        cnt_clr,
    output logic                        y,
    output logic [BEH_COND_TABLE_W-1:0] cfg_table,
    output logic [CNT_W-1:0]            chg_cnt
);

    beh_cond_table_t           table_q, table_d;
    logic                      y_prev_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BEH_COND_IDX_W-1:0] idx;
    logic                      f;

    assign idx = {a, b, c, d};

    beh_cond_lut u_lut (
        .table_i (table_q),
        .idx_i   (idx),
        .f_o     (f)
    );

`ifdef BEH_COND_REG_OUT_EN
    logic y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= f;
        end
    end

    assign y = y_q;
`else
    assign y = f;
`endif

    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            table_d = cfg_data;
        end
    end

    // Clear wins over increment; increment holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((y != y_prev_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            table_q  <= DEFAULT_TABLE;
            y_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            table_q  <= table_d;
            y_prev_q <= y;
            cnt_q    <= cnt_d;
        end
    end

    assign cfg_table = table_q;
    assign chg_cnt   = cnt_q;

endmodule

// File: tb/tb_beh_cond.sv
// Directed self-checking bench for beh_cond; follows BEH_COND_REG_OUT_EN for y latency.
module tb_beh_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a, b, c, d;
    logic        cfg_we;
    logic [15:0] cfg_data;
    logic        cnt_clr;
    logic        y;
    logic [15:0] cfg_table;
    logic [7:0]  chg_cnt;

    int n_checks = 0;
    int n_errors = 0;

    beh_cond #(.CNT_W(8), .DEFAULT_TABLE(16'hF066)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .cnt_clr   (cnt_clr),
        .y         (y),
        .cfg_table (cfg_table),
        .chg_cnt   (chg_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_idx(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    logic [15:0] sweep_exp;
    logic        y_rst_exp;

    initial begin
        // Hand-derived default-table outputs for idx 0..15: 0,1,1,0,0,1,1,0,0,0,0,0,1,1,1,1
        sweep_exp = 16'b1111_0000_0110_0110;
`ifdef BEH_COND_REG_OUT_EN
        y_rst_exp = 1'b0;
`else
        y_rst_exp = 1'b1;
`endif
        rst_n = 1'b0; cfg_we = 1'b0; cfg_data = 16'h0; cnt_clr = 1'b0;
        set_idx(4'h0);
        cyc(2);
        check("rst_table", cfg_table, 16'hF066);
        check("rst_cnt", chg_cnt, 0);
        check("rst_y", y, 0);
        rst_n = 1'b1;
        cyc(1);

        // Exhaustive sweep of the default table
        for (int i = 0; i < 16; i++) begin
            set_idx(4'(i));
            cyc(1);
            check($sformatf("sweep_%0d", i), y, sweep_exp[i]);
        end

        // Change counter: d 0->1->0 at a=b=c=0
        set_idx(4'h0);
        cnt_clr = 1'b1;
        cyc(3);
        cnt_clr = 1'b0;
        cyc(1);
        check("cnt_start", chg_cnt, 0);
        d = 1'b1;
        cyc(3);
        d = 1'b0;
        cyc(3);
        check("cnt_two", chg_cnt, 2);
        cnt_clr = 1'b1;
        cyc(1);
        check("cnt_clr", chg_cnt, 0);
        cnt_clr = 1'b0;

        // Table write: lookup in the write cycle still uses the old table
        set_idx(4'h0);
        cfg_we = 1'b1; cfg_data = 16'h8001;
`ifdef BEH_COND_REG_OUT_EN
        cyc(1);
        check("wr_old", y, 0);
`else
        #2;
        check("wr_old", y, 0);
        cyc(1);
`endif
        cfg_we = 1'b0;
        cyc(1);
        check("wr_idx0", y, 1);
        set_idx(4'hF);
        cyc(1);
        check("wr_idx15", y, 1);
        set_idx(4'h5);
        cyc(1);
        check("wr_idx5", y, 0);
        check("wr_table", cfg_table, 16'h8001);

        // Saturation: every d toggle at idx 0/1 flips y under table 0001
        cfg_we = 1'b1; cfg_data = 16'h0001;
        set_idx(4'h0);
        cyc(1);
        cfg_we = 1'b0;
        for (int i = 0; i < 300; i++) begin
            d = ~d;
            cyc(1);
        end
        cyc(3);
        check("sat_255", chg_cnt, 255);
        d = ~d;
        cnt_clr = 1'b1;
        cyc(1);
        check("sat_clr", chg_cnt, 0);
        cnt_clr = 1'b0;
        cyc(3);

        // Reset mid-operation discards a concurrent table write
        cfg_we = 1'b1; cfg_data = 16'h1234;
        set_idx(4'h0);
        cyc(1);
        cfg_we = 1'b0;
        check("mid_table", cfg_table, 16'h1234);
        cnt_clr = 1'b1;
        cyc(2);
        cnt_clr = 1'b0;
        b = 1'b1;
        cyc(2);
        b = 1'b0;
        cyc(3);
        check("mid_cnt", chg_cnt, 2);
        set_idx(4'h1);
        rst_n = 1'b0; cfg_we = 1'b1; cfg_data = 16'hAAAA; cnt_clr = 1'b0;
        cyc(1);
        check("mrst_table", cfg_table, 16'hF066);
        check("mrst_cnt", chg_cnt, 0);
        check("mrst_y", y, y_rst_exp);
        rst_n = 1'b1; cfg_we = 1'b0;
        cyc(1);
        check("mrst_nowr", cfg_table, 16'hF066);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
